// File: rtl/video_stream_pkg.sv
// Shared types and helpers for the AXI4-Stream video sources, filters and checkers.
package video_stream_pkg;

    typedef enum logic [1:0] {
        PAT_XRAMP   = 2'd0,
        PAT_YRAMP   = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_CONST   = 2'd3
    } pat_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_pattern_pixel.sv
// Combinational test-pattern pixel for coordinate (x, y); shared by the generator and frame checkers.
module axis_pattern_pixel
    import video_stream_pkg::*;
#(
    parameter int P_DAT_WIDTH = 8,
    parameter int P_X_WIDTH   = 8,
    parameter int P_Y_WIDTH   = 8
) (
    input  pat_mode_t              mode,
    input  logic [P_X_WIDTH-1:0]   x,
    input  logic [P_Y_WIDTH-1:0]   y,
    input  logic [P_DAT_WIDTH-1:0] const_val,
    output logic [P_DAT_WIDTH-1:0] pixel
);

    logic x_b3;
    logic y_b3;

    // Bit 3 of each coordinate, reading as 0 when the counter is narrower than four bits.
    assign x_b3 = 1'(x >> 3);
    assign y_b3 = 1'(y >> 3);

    always_comb begin
        pixel = '0;
        case (mode)
            PAT_XRAMP:   pixel = P_DAT_WIDTH'(x);
            PAT_YRAMP:   pixel = P_DAT_WIDTH'(y);
            PAT_CHECKER: pixel = (x_b3 ^ y_b3) ? '1 : '0;
            PAT_CONST:   pixel = const_val;
            default:     pixel = '0;
        endcase
    end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video pattern source: SOF on tuser, EOL on tlast, blanking between lines.
// Define PATGEN_STALL_CNT_EN to add the o_stall_cnt backpressure counter output.
module axis_video_pattern_gen
    import video_stream_pkg::*;
#(
    parameter int P_DAT_WIDTH  = 8,
    parameter int P_IMG_WIDTH  = 200,
    parameter int P_IMG_HEIGHT = 200,
    parameter int P_BLK_CYCLE  = 30
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_start,
    input  logic                   i_cont,
    input  logic [1:0]             i_mode,
    input  logic [P_DAT_WIDTH-1:0] i_const,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic [P_DAT_WIDTH-1:0] o_maxis_tdata,
    output logic                   o_maxis_tvalid,
    input  logic                   i_maxis_tready,
    output logic                   o_maxis_tuser,
    output logic                   o_maxis_tlast,
`ifdef PATGEN_STALL_CNT_EN
    output logic [31:0]            o_stall_cnt,
`endif
    output state_t                 o_dbg_state
);

    localparam int XW = cnt_width(P_IMG_WIDTH);
    localparam int YW = cnt_width(P_IMG_HEIGHT);
    localparam int BW = cnt_width(P_BLK_CYCLE + 1);

    localparam logic [XW-1:0] X_LAST = XW'(P_IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(P_IMG_HEIGHT - 1);
    localparam logic [BW-1:0] B_LAST = BW'((P_BLK_CYCLE > 0) ? P_BLK_CYCLE - 1 : 0);

    state_t                 state;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [BW-1:0]          blk_cnt;
    pat_mode_t              mode_q;
    logic [P_DAT_WIDTH-1:0] const_q;
    logic [P_DAT_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tuser;
    logic                   tlast;
    logic                   busy;
    logic                   frame_done;

    // Coordinates and settings of the beat that will be loaded into the output register next.
    pat_mode_t              ld_mode;
    logic [P_DAT_WIDTH-1:0] ld_const;
    logic [XW-1:0]          ld_x;
    logic [YW-1:0]          ld_y;
    logic [P_DAT_WIDTH-1:0] ld_pixel;

    always_comb begin
        ld_mode  = mode_q;
        ld_const = const_q;
        ld_x     = x;
        ld_y     = y;
        case (state)
            ST_IDLE, ST_DONE: begin
                ld_mode  = pat_mode_t'(i_mode);
                ld_const = i_const;
                ld_x     = '0;
                ld_y     = '0;
            end
            ST_ACTIVE: begin
                if (x == X_LAST) begin
                    ld_x = '0;
                    ld_y = y + 1'b1;
                end else begin
                    ld_x = x + 1'b1;
                end
            end
            ST_HBLANK: ld_x = '0;
            default: ld_x = '0;
        endcase
    end

    axis_pattern_pixel #(
        .P_DAT_WIDTH (P_DAT_WIDTH),
        .P_X_WIDTH   (XW),
        .P_Y_WIDTH   (YW)
    ) u_pixel (
        .mode      (ld_mode),
        .x         (ld_x),
        .y         (ld_y),
        .const_val (ld_const),
        .pixel     (ld_pixel)
    );

    // Handshake: a beat moves on tvalid & tready; while tvalid=1 and tready=0 the beat
    // (tdata/tuser/tlast) is held and tvalid stays high until it is taken.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= ST_IDLE;
            x          <= '0;
            y          <= '0;
            blk_cnt    <= '0;
            mode_q     <= PAT_XRAMP;
            const_q    <= '0;
            tdata      <= '0;
            tvalid     <= 1'b0;
            tuser      <= 1'b0;
            tlast      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        mode_q  <= ld_mode;
                        const_q <= ld_const;
                        x       <= '0;
                        y       <= '0;
                        tdata   <= ld_pixel;
                        tvalid  <= 1'b1;
                        tuser   <= 1'b1;
                        tlast   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (i_maxis_tready) begin
                        tuser <= 1'b0;
                        if (x != X_LAST) begin
                            x     <= ld_x;
                            tdata <= ld_pixel;
                            tlast <= (ld_x == X_LAST);
                        end else begin
                            x     <= '0;
                            tlast <= 1'b0;
                            if (y != Y_LAST) begin
                                y <= ld_y;
                                if (P_BLK_CYCLE == 0) begin
                                    tdata <= ld_pixel;
                                end else begin
                                    tvalid  <= 1'b0;
                                    blk_cnt <= '0;
                                    state   <= ST_HBLANK;
                                end
                            end else begin
                                tvalid     <= 1'b0;
                                frame_done <= 1'b1;
                                state      <= ST_DONE;
                            end
                        end
                    end
                end
                ST_HBLANK: begin
                    if (blk_cnt == B_LAST) begin
                        tdata  <= ld_pixel;
                        tvalid <= 1'b1;
                        tuser  <= 1'b0;
                        tlast  <= 1'b0;
                        state  <= ST_ACTIVE;
                    end else begin
                        blk_cnt <= blk_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    y <= '0;
                    if (i_cont) begin
                        mode_q  <= ld_mode;
                        const_q <= ld_const;
                        tdata   <= ld_pixel;
                        tvalid  <= 1'b1;
                        tuser   <= 1'b1;
                        tlast   <= 1'b0;
                        state   <= ST_ACTIVE;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PATGEN_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_cnt <= '0;
        end else if (state == ST_IDLE && i_start) begin
            stall_cnt <= '0;
        end else if (tvalid && !i_maxis_tready && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`endif

    assign o_busy         = busy;
    assign o_frame_done   = frame_done;
    assign o_maxis_tdata  = tdata;
    assign o_maxis_tvalid = tvalid;
    assign o_maxis_tuser  = tuser;
    assign o_maxis_tlast  = tlast;
    assign o_dbg_state    = state;

endmodule
